// File: rtl/stream_sink_pkg.sv
// Package shared by the stream sink and the stream source blocks.
// Holds the default token/address widths and the width of the accepted-token counter.
package stream_sink_pkg;

    localparam int unsigned DataWidth  = 16;  // default token width
    localparam int unsigned AddrWidth  = 4;   // default FIFO address width, depth = 2**AddrWidth
    localparam int unsigned CountWidth = 32;  // accepted-token counter width

endpackage

// File: rtl/stream_sink_if.sv
// Token/read bus between an upstream operator plus host and the stream sink.
// Signals:
//   r_in1    : token valid from the upstream operator
//   d_in1    : token data
//   rd_en    : host read request
//   rd_valid : one-cycle pulse, rd_data holds a freshly popped token
//   rd_data  : last popped token
// The master modport drives the bus (upstream/host). The slave modport is the sink.
interface stream_sink_if #(
    parameter int unsigned N = 16
) ();

    logic         r_in1;
    logic [N-1:0] d_in1;
    logic         rd_en;
    logic         rd_valid;
    logic [N-1:0] rd_data;

    modport master (
        output r_in1,
        output d_in1,
        output rd_en,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  r_in1,
        input  d_in1,
        input  rd_en,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// 2**A x N register array with one write port and one registered read port.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears only the read register
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable, loads rdata_o on the next edge
//   raddr_i : read address
//   rdata_o : registered read data, holds between reads
module sync_fifo_mem #(
    parameter int unsigned N = 16,
    parameter int unsigned A = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [A-1:0] waddr_i,
    input  logic [N-1:0] wdata_i,
    input  logic         re_i,
    input  logic [A-1:0] raddr_i,
    output logic [N-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << A;

    logic [N-1:0] mem_q [Depth];
    logic [N-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-edge write to raddr_i is not visible here: the old entry is read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_sink.sv
// Terminal consumer of the operator token stream. Buffers accepted tokens in a FIFO and
// hands them to the host through a registered read handshake. Also tracks the
// accepted-token count, overflow and completion.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   en_i    : input-side enable, r_in1 ignored when low
//   bus     : token input and host read handshake (slave side)
//   empty_o : FIFO holds no tokens
//   full_o  : FIFO holds 2**A tokens
//   level_o : occupancy 0..2**A
//   ovf_o   : sticky, a token was dropped because the FIFO was full
//   count_o : tokens accepted since reset, wraps
//   done_o  : sticky, count_o reached T (never set when T == 0)
module stream_sink
    import stream_sink_pkg::*;
#(
    parameter int unsigned N = DataWidth,
    parameter int unsigned A = AddrWidth,
    parameter int unsigned T = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    stream_sink_if.slave          bus,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [A:0]            level_o,
    output logic                  ovf_o,
    output logic [CountWidth-1:0] count_o,
    output logic                  done_o
);

    localparam logic [A:0]            LevelFull   = {1'b1, {A{1'b0}}};
    localparam logic [CountWidth-1:0] TargetCount = CountWidth'(T);

    logic [A-1:0]            wptr_q, wptr_d;
    logic [A-1:0]            rptr_q, rptr_d;
    logic [A:0]              level_q, level_d;
    logic                    empty_q, full_q;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic                    rd_valid_q;
    logic [CountWidth-1:0]   count_q, count_d;
    logic [N-1:0]            rd_data;
    logic                    wr, rd, drop;

    always_comb begin
        rd   = bus.rd_en && !empty_q;
        // When full, a simultaneous read frees the slot this write lands in.
        wr   = en_i && bus.r_in1 && (!full_q || rd);
        drop = en_i && bus.r_in1 && full_q && !rd;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        count_d = count_q;
        ovf_d   = ovf_q | drop;
        done_d  = done_q;

        if (wr) begin
            wptr_d  = wptr_q + 1'b1;
            count_d = count_q + 1'b1;
        end
        if (rd) begin
            rptr_d = rptr_q + 1'b1;
        end

        unique case ({wr, rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Only the accepting write can make the count hit the target, so a later
        // wrap past it leaves done set.
        if (wr && (T != 0) && (count_d == TargetCount)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == LevelFull);
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            count_q    <= count_d;
            rd_valid_q <= rd;
        end
    end

    sync_fifo_mem #(
        .N(N),
        .A(A)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr),
        .waddr_i (wptr_q),
        .wdata_i (bus.d_in1),
        .re_i    (rd),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data;
    assign empty_o      = empty_q;
    assign full_o       = full_q;
    assign level_o      = level_q;
    assign ovf_o        = ovf_q;
    assign count_o      = count_q;
    assign done_o       = done_q;

endmodule
